pipelined_barrel_shifter: RTL and testbench
===========================================

# pipelined_barrel_shifter

Parametrised, pipelined logarithmic barrel shifter supporting SLL, SRL, SRA and optional ROR on an N-bit operand. It has a valid/ready handshake on both sides and one register per shift level, giving full throughput and a fixed latency of log2(N) cycles. It sits between the ALU operand muxes and the writeback register, replacing the single-cycle combinational shift units in multi-cycle and pipelined datapaths.

## Interface
- N, default 32: operand width. Must be a power of two and ≥ 4.
- TAG_W, default 4: width of the sideband tag carried alongside each operation.
- S (derived, not overridable): $clog2(N), which is both the shamt width and the pipeline depth.
- clk  input  1: single clock, rising edge.
- rst_n  input  1: reset, asynchronous, active-low.
- in_valid  input  1: input operation is valid.
- in_ready  output  1: block can accept an input this cycle.
- in_data  input  N: operand.
- in_shamt  input  S: shift amount, unsigned, 0..N-1.
- in_op  input  2: operation select. 00 = SLL, 01 = SRL, 10 = SRA, 11 = ROR.
- in_tag  input  TAG_W: sideband tag, returned unchanged with the result.
- out_valid  output  1: result is valid.
- out_ready  input  1: consumer accepts the result.
- out_data  output  N: shifted result.
- out_tag  output  TAG_W: tag of this result.

## Operation
- The pipeline has S stages. Stage k (k = 0..S-1) shifts its operand by 2^k when shamt[k] = 1, otherwise it passes the operand through. Each stage registers data, shamt, op, tag and a valid bit.
- Fill rules per stage:
  - SLL: zeros enter at the LSB side.
  - SRL: zeros enter at the MSB side.
  - SRA: copies of the stage input's MSB enter at the MSB side. The MSB never changes during SRA, so this equals the original sign.
  - ROR: bits leaving the LSB side re-enter at the MSB side.
- The final result equals the mathematical operation on the original operand modulo 2^N.
- shamt = 0 returns in_data unchanged for every op.
- Stall is global: stall = out_valid & ~out_ready.
  - When stall = 1, every stage register holds its value.
  - in_ready = ~stall, combinational from out_valid and out_ready.
- A transfer occurs on a rising clk edge with in_valid & in_ready (input side) or out_valid & out_ready (output side).
- Bubbles (invalid stages) advance when not stalled and are not compressed.
- Data, shamt and tag registers of an invalid stage may load arbitrary values. out_data and out_tag are don't-care while out_valid = 0.
- There is no internal FSM. State is the S valid bits plus the stage payloads.

## Timing
- Reset (rst_n low, asynchronous): all stage valid bits and all payload registers go to 0, so out_valid = 0, out_data = 0 and out_tag = 0. in_ready = 1 as soon as reset asserts.
- Assertion of rst_n mid-operation drops every in-flight operation, with no partial outputs.
- Deassertion of rst_n is synchronised externally. The first transfer can occur at the first rising edge after deassertion.
- Latency: an input accepted at edge t appears with out_valid = 1 after edge t+S−1 (visible in the cycle following edge t+S−1), provided there is no stall. This is S cycles from input cycle to output cycle.
- Throughput is one operation per cycle while out_ready = 1.
- A simultaneous output transfer and input acceptance in the same cycle is legal and required for full throughput.
- in_valid may drop without a transfer. Once out_valid is high, it and the output payload stay stable until out_ready.

## Configuration
- PIPELINED_BARREL_SHIFTER_ROR_EN:
  - Defined: op 11 performs rotate-right as described above.
  - Undefined: the rotate fill logic is not compiled, and op 11 behaves exactly as SRL (01). The ports are unchanged.

## Test plan
All cases use N=32, so latency is 5 cycles.
- Reset: with rst_n low, out_valid=0, out_data=0, out_tag=0 and in_ready=1. Drop rst_n while 3 ops are in flight, release it, and confirm no outputs ever appear.
- SRA: in_data=0x8000_0F00, shamt=4, op=10 -> out_data=0xF800_00F0 after 5 cycles, tag preserved. in_data=0x7000_0000, shamt=31 -> 0x0000_0000.
- SLL/SRL: 0x0000_0001 with shamt=31 and op=00 -> 0x8000_0000. 0x8000_0000 with shamt=31 and op=01 -> 0x0000_0001. Any data with shamt=0 returns unchanged.
- ROR: 0x0000_0001 with shamt=1 -> 0x8000_0000 with the macro defined, 0x0000_0000 without it.
- Throughput: 100 back-to-back random ops with out_ready=1 yield 100 in-order results, one per cycle, first at cycle 5, all matching a reference model.
- Backpressure: toggle out_ready randomly (50%) with a continuous input stream. Check:
  - no loss, duplication or reordering (checked by tag sequence);
  - out_data/out_tag stable while stalled;
  - in_ready = 0 exactly when out_valid & ~out_ready.

Source files
------------

// File: rtl/pipelined_barrel_shifter_if.sv
// Handshake bundle for pipelined_barrel_shifter: operand side (in_*) and result side (out_*).
// Valid/ready on both sides: a beat moves on a rising edge where valid & ready are both 1; the source keeps valid and payload stable until then.
interface pipelined_barrel_shifter_if #(
  parameter int N     = 32,
  parameter int TAG_W = 4
);
  localparam int S = $clog2(N);

  logic             in_valid;
  logic             in_ready;
  logic [N-1:0]     in_data;
  logic [S-1:0]     in_shamt;
  logic [1:0]       in_op;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [N-1:0]     out_data;
  logic [TAG_W-1:0] out_tag;

  modport master (
    output in_valid, in_data, in_shamt, in_op, in_tag, out_ready,
    input  in_ready, out_valid, out_data, out_tag
  );

  modport slave (
    input  in_valid, in_data, in_shamt, in_op, in_tag, out_ready,
    output in_ready, out_valid, out_data, out_tag
  );
endinterface

// File: rtl/pipelined_barrel_shifter.sv
// Logarithmic barrel shifter with one register per shift level (SLL/SRL/SRA, ROR under
// PIPELINED_BARREL_SHIFTER_ROR_EN; without it op 11 acts as SRL). Latency $clog2(N), one op per cycle.
module pipelined_barrel_shifter #(
  parameter int N     = 32,
  parameter int TAG_W = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  pipelined_barrel_shifter_if.slave  bus
);
  localparam int S = $clog2(N);

  if (N < 4 || (N & (N - 1)) != 0) begin : g_bad_width
    $error("pipelined_barrel_shifter: N must be a power of two and at least 4");
  end

  logic [S-1:0]            valid_q, valid_d;
  logic [S-1:0][N-1:0]     data_q,  data_d;
  logic [S-1:0][S-1:0]     shamt_q, shamt_d;
  logic [S-1:0][1:0]       op_q,    op_d;
  logic [S-1:0][TAG_W-1:0] tag_q,   tag_d;

  // Stage k reads element k: element 0 is the input port, element k>0 is stage k-1.
  logic [S-1:0]            src_valid;
  logic [S-1:0][N-1:0]     src_data;
  logic [S-1:0][S-1:0]     src_shamt;
  logic [S-1:0][1:0]       src_op;
  logic [S-1:0][TAG_W-1:0] src_tag;

  logic stall;
  logic unused_last_stage;

  function automatic logic [N-1:0] shift_level(input logic [N-1:0] d,
                                               input logic [1:0]   op,
                                               input int           amt);
    logic [N-1:0] r;
    case (op)
      2'b00:   r = d << amt;
      2'b01:   r = d >> amt;
      2'b10:   r = N'($signed(d) >>> amt);
`ifdef PIPELINED_BARREL_SHIFTER_ROR_EN
      2'b11:   r = (d >> amt) | (d << (N - amt));
`else
      2'b11:   r = d >> amt;
`endif
      default: r = d;
    endcase
    return r;
  endfunction

  assign src_valid = {valid_q[S-2:0], bus.in_valid};
  assign src_data  = {data_q[S-2:0],  bus.in_data};
  assign src_shamt = {shamt_q[S-2:0], bus.in_shamt};
  assign src_op    = {op_q[S-2:0],    bus.in_op};
  assign src_tag   = {tag_q[S-2:0],   bus.in_tag};

  // A single global stall freezes every level, so bubbles are never squeezed out.
  assign stall        = valid_q[S-1] & ~bus.out_ready;
  assign bus.in_ready = ~stall;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    shamt_d = shamt_q;
    op_d    = op_q;
    tag_d   = tag_q;
    if (!stall) begin
      valid_d = src_valid;
      shamt_d = src_shamt;
      op_d    = src_op;
      tag_d   = src_tag;
      for (int k = 0; k < S; k++) begin
        data_d[k] = src_shamt[k][k] ? shift_level(src_data[k], src_op[k], 1 << k)
                                    : src_data[k];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      data_q  <= '0;
      shamt_q <= '0;
      op_q    <= '0;
      tag_q   <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      shamt_q <= shamt_d;
      op_q    <= op_d;
      tag_q   <= tag_d;
    end
  end

  assign bus.out_valid = valid_q[S-1];
  assign bus.out_data  = data_q[S-1];
  assign bus.out_tag   = tag_q[S-1];

  // The last level's shamt/op are only kept for a uniform register layout.
  assign unused_last_stage = ^{shamt_q[S-1], op_q[S-1]};
endmodule

// File: tb/tb_pipelined_barrel_shifter.sv
// Self-checking bench for pipelined_barrel_shifter (N=32, latency 5); honours PIPELINED_BARREL_SHIFTER_ROR_EN.
module tb_pipelined_barrel_shifter;
  localparam int N     = 32;
  localparam int TAG_W = 4;
  localparam int S     = $clog2(N);
  localparam int W     = N + TAG_W;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   passed = 0;
  logic [W-1:0] exp_q[$];

  pipelined_barrel_shifter_if #(.N(N), .TAG_W(TAG_W)) bus ();

  pipelined_barrel_shifter #(.N(N), .TAG_W(TAG_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  // Reference: shifts as multiply/divide by 2**s on the whole operand.
  function automatic logic [W-1:0] model(input logic [N-1:0] d, input int s,
                                         input logic [1:0] op, input logic [TAG_W-1:0] t);
    longint unsigned ud   = 64'(d);
    longint unsigned p    = 64'd1 << s;
    longint unsigned mask = (64'd1 << N) - 64'd1;
    longint unsigned r;
    case (op)
      2'b00:   r = (ud * p) & mask;
      2'b01:   r = ud / p;
      2'b10:   r = d[N-1] ? (~((~ud & mask) / p)) & mask : ud / p;
`ifdef PIPELINED_BARREL_SHIFTER_ROR_EN
      default: r = ((ud / p) | (ud * (64'd1 << (N - s)))) & mask;
`else
      default: r = ud / p;
`endif
    endcase
    return {t, r[N-1:0]};
  endfunction

  task automatic drive_random(input logic [TAG_W-1:0] t);
    bus.in_data  = $urandom;
    bus.in_shamt = S'($urandom_range(0, N - 1));
    bus.in_op    = 2'($urandom_range(0, 3));
    bus.in_tag   = t;
  endtask

  task automatic test_reset();
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    drive_random(4'h0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (bus.out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); else passed++;
    checks++; if (bus.out_data !== '0) $display("FAIL reset_out_data: got %h want 0", bus.out_data); else passed++;
    checks++; if (bus.out_tag !== '0) $display("FAIL reset_out_tag: got %h want 0", bus.out_tag); else passed++;
    checks++; if (bus.in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", bus.in_ready); else passed++;
    @(posedge clk); #1;
    rst_n         = 1'b1;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.in_valid = 1'b1;
      drive_random(4'(i + 1));
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    checks++; if (bus.out_valid !== 1'b0) $display("FAIL async_reset_out_valid: got %b want 0", bus.out_valid); else passed++;
    checks++; if (bus.in_ready !== 1'b1) $display("FAIL async_reset_in_ready: got %b want 1", bus.in_ready); else passed++;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      checks++; if (bus.out_valid !== 1'b0) $display("FAIL flushed_no_output: cycle %0d got out_valid %b want 0", c, bus.out_valid); else passed++;
    end
    exp_q.delete();
  endtask

  task automatic test_directed();
    logic [N-1:0] d_in  [9] = '{32'h8000_0F00, 32'h7000_0000, 32'h0000_0001, 32'h8000_0000,
                                32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'h8765_4321, 32'h0000_0001,
                                32'h8000_0000};
    int           d_sh  [9] = '{4, 31, 31, 31, 0, 0, 0, 1, 31};
    logic [1:0]   d_op  [9] = '{2'b10, 2'b10, 2'b00, 2'b01, 2'b00, 2'b10, 2'b11, 2'b11, 2'b10};
`ifdef PIPELINED_BARREL_SHIFTER_ROR_EN
    logic [N-1:0] d_exp [9] = '{32'hF800_00F0, 32'h0000_0000, 32'h8000_0000, 32'h0000_0001,
                                32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'h8765_4321, 32'h8000_0000,
                                32'hFFFF_FFFF};
`else
    logic [N-1:0] d_exp [9] = '{32'hF800_00F0, 32'h0000_0000, 32'h8000_0000, 32'h0000_0001,
                                32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'h8765_4321, 32'h0000_0000,
                                32'hFFFF_FFFF};
`endif
    int n;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      @(posedge clk); #1;
      bus.in_valid = 1'b1;
      bus.in_data  = d_in[i];
      bus.in_shamt = S'(d_sh[i]);
      bus.in_op    = d_op[i];
      bus.in_tag   = 4'(i + 5);
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      n = 1;
      while (n < 20) begin
        @(negedge clk);
        if (bus.out_valid === 1'b1) break;
        @(posedge clk);
        n++;
      end
      checks++;
      if (bus.out_valid !== 1'b1) $display("FAIL dir%0d_timeout: no out_valid within %0d cycles", i, n);
      else if (n !== S) $display("FAIL dir%0d_latency: got %0d want %0d", i, n, S);
      else passed++;
      checks++; if (bus.out_data !== d_exp[i]) $display("FAIL dir%0d_data: got %h want %h", i, bus.out_data, d_exp[i]); else passed++;
      checks++; if (bus.out_tag !== 4'(i + 5)) $display("FAIL dir%0d_tag: got %h want %h", i, bus.out_tag, 4'(i + 5)); else passed++;
    end
    repeat (3) @(posedge clk);
  endtask

  task automatic test_back_to_back();
    int sent = 0, got = 0, cyc = 0, gaps = 0, first_in = -1, first_out = -1;
    logic [W-1:0] e;
    bit advance = 1'b1;
    exp_q.delete();
    bus.out_ready = 1'b1;
    while (got < 100 && cyc < 400) begin
      @(posedge clk); cyc++; #1;
      bus.in_valid = (sent < 100);
      if (advance) drive_random(4'(sent));
      @(negedge clk);
      if (bus.out_valid === 1'b1) begin
        if (first_out < 0) first_out = cyc;
        checks++;
        if (exp_q.size() == 0) $display("FAIL b2b_unexpected: data %h tag %h with empty queue", bus.out_data, bus.out_tag);
        else begin
          e = exp_q.pop_front();
          if ({bus.out_tag, bus.out_data} !== e) $display("FAIL b2b_result%0d: got %h want %h", got, {bus.out_tag, bus.out_data}, e);
          else passed++;
        end
        got++;
      end else if (first_out >= 0) gaps++;
      advance = bus.in_valid & bus.in_ready;
      if (advance) begin
        exp_q.push_back(model(bus.in_data, int'(bus.in_shamt), bus.in_op, bus.in_tag));
        if (first_in < 0) first_in = cyc;
        sent++;
      end
    end
    bus.in_valid = 1'b0;
    checks++; if (got !== 100) $display("FAIL b2b_count: got %0d want 100", got); else passed++;
    checks++; if (first_out - first_in !== S) $display("FAIL b2b_first_latency: got %0d want %0d", first_out - first_in, S); else passed++;
    checks++; if (gaps !== 0) $display("FAIL b2b_gaps: got %0d want 0", gaps); else passed++;
    repeat (3) @(posedge clk);
  endtask

  task automatic test_backpressure();
    int sent = 0, got = 0, cyc = 0;
    logic [W-1:0] e;
    logic [N-1:0] prev_data;
    logic [TAG_W-1:0] prev_tag;
    bit advance = 1'b1, prev_stall = 1'b0, feeding = 1'b1;
    exp_q.delete();
    while (cyc < 300 && (feeding || exp_q.size() != 0)) begin
      @(posedge clk); cyc++; #1;
      feeding       = (cyc <= 200);
      bus.in_valid  = feeding;
      bus.out_ready = feeding ? 1'($urandom_range(0, 1)) : 1'b1;
      if (advance) drive_random(4'(sent));
      @(negedge clk);
      checks++;
      if (bus.in_ready !== ~(bus.out_valid & ~bus.out_ready))
        $display("FAIL bp_in_ready: got %b want %b", bus.in_ready, ~(bus.out_valid & ~bus.out_ready));
      else passed++;
      if (prev_stall) begin
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== prev_data || bus.out_tag !== prev_tag)
          $display("FAIL bp_stable: got v%b %h/%h want v1 %h/%h", bus.out_valid, bus.out_data, bus.out_tag, prev_data, prev_tag);
        else passed++;
      end
      if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) $display("FAIL bp_unexpected: data %h tag %h with empty queue", bus.out_data, bus.out_tag);
        else begin
          e = exp_q.pop_front();
          if ({bus.out_tag, bus.out_data} !== e) $display("FAIL bp_result%0d: got %h want %h", got, {bus.out_tag, bus.out_data}, e);
          else passed++;
        end
        got++;
      end
      prev_stall = bus.out_valid & ~bus.out_ready;
      prev_data  = bus.out_data;
      prev_tag   = bus.out_tag;
      advance    = bus.in_valid & bus.in_ready;
      if (advance) begin
        exp_q.push_back(model(bus.in_data, int'(bus.in_shamt), bus.in_op, bus.in_tag));
        sent++;
      end
    end
    bus.in_valid = 1'b0;
    checks++; if (exp_q.size() !== 0) $display("FAIL bp_drain: %0d results missing", exp_q.size()); else passed++;
    checks++; if (got !== sent) $display("FAIL bp_count: got %0d outputs want %0d", got, sent); else passed++;
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_backpressure();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("%0d/%0d checks passed", passed, checks + 1);
    $fatal(1, "watchdog expired");
  end
endmodule
